// File: rtl/seq_multiplier_16bit_pkg.sv
// Shared constants for the 16x16 sequential shift-and-add multiplier:
// FSM encodings, iteration count and the operand magnitude helper.
package seq_multiplier_16bit_pkg;

    localparam int WIDTH = 16;
    localparam int ITER  = 16;
    localparam int CNT_W = 5;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PREP = 3'd1;
    localparam logic [2:0] ST_CALC = 3'd2;
    localparam logic [2:0] ST_FIX  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    // -32768 maps to 0x8000, which the unsigned datapath reads as +32768.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? (~x + 16'd1) : x;
    endfunction

endpackage

// File: rtl/seq_multiplier_16bit_if.sv
// Start/busy/done handshake and operand/result bus between the execute
// stage (master) and the multiplier (slave).
interface seq_multiplier_16bit_if;
    import seq_multiplier_16bit_pkg::*;

    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, is_signed, a, b,
                    input  busy, done, hi, lo);
    modport slave  (input  start, is_signed, a, b,
                    output busy, done, hi, lo);

endinterface

// File: rtl/seq_multiplier_16bit_cla.sv
// 16-bit carry-lookahead adder built from four 4-bit groups; no carry-out
// port, so callers rebuild the carry from the operand and sum MSBs.
module CarryLookaheadAdder16Bit (
    output logic [15:0] sum,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        c_in
);

    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] c;
    logic [2:0]  grp_g;
    logic [2:0]  grp_p;
    logic [3:0]  blk_c;

    assign g = a & b;
    assign p = a ^ b;

    // NOTE: every variable gets a default at the top so no latch is inferred.
    always_comb begin
        c     = '0;
        grp_g = '0;
        grp_p = '0;
        blk_c = '0;
        // Only the lower three groups feed a later group's carry-in.
        for (int k = 0; k < 3; k++) begin
            grp_g[k] = g[4*k+3]
                     | (p[4*k+3] & g[4*k+2])
                     | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            grp_p[k] = &p[4*k +: 4];
        end
        blk_c[0] = c_in;
        for (int k = 0; k < 3; k++) begin
            blk_c[k+1] = grp_g[k] | (grp_p[k] & blk_c[k]);
        end
        for (int k = 0; k < 4; k++) begin
            c[4*k] = blk_c[k];
            for (int i = 0; i < 3; i++) begin
                c[4*k+i+1] = g[4*k+i] | (p[4*k+i] & c[4*k+i]);
            end
        end
    end

    assign sum = p ^ c;

endmodule

// File: rtl/seq_multiplier_16bit.sv
// Fixed 18-cycle 16x16->32 shift-and-add multiplier for MULT/MULTU,
// producing the HI/LO pair with a start/busy/done handshake.
module seq_multiplier_16bit
    import seq_multiplier_16bit_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    seq_multiplier_16bit_if.slave bus
);

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] q;
    logic             sgn;
    logic             neg;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;

    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   sum_s;
    logic               carry;
    logic [2*WIDTH-1:0] fixed;

    assign addend = q[0] ? mcand : '0;

    CarryLookaheadAdder16Bit u_cla (
        .sum  (sum_s),
        .a    (acc),
        .b    (addend),
        .c_in (1'b0)
    );

    assign carry = (acc[WIDTH-1] & addend[WIDTH-1])
                 | ((acc[WIDTH-1] ^ addend[WIDTH-1]) & ~sum_s[WIDTH-1]);

    // Sign correction of the full 32-bit product; wraps modulo 2^32.
    assign fixed = neg ? (~{acc, q} + 32'd1) : {acc, q};

    // NOTE: state is updated with non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            mcand <= '0;
            acc   <= '0;
            q     <= '0;
            sgn   <= 1'b0;
            neg   <= 1'b0;
            hi_r  <= '0;
            lo_r  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        mcand <= bus.a;
                        q     <= bus.b;
                        sgn   <= bus.is_signed;
                        neg   <= bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        state <= ST_PREP;
                    end
                end
                ST_PREP: begin
                    if (sgn) begin
                        mcand <= magnitude(mcand);
                        q     <= magnitude(q);
                    end
                    acc   <= '0;
                    cnt   <= '0;
                    state <= ST_CALC;
                end
                ST_CALC: begin
                    // Shift {carry, sum, q} right by one; the product bit
                    // falling out of the sum enters q from the top.
                    acc <= {carry, sum_s[WIDTH-1:1]};
                    q   <= {sum_s[0], q[WIDTH-1:1]};
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(ITER - 1)) begin
                        state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    {acc, q} <= fixed;
                    hi_r     <= fixed[2*WIDTH-1:WIDTH];
                    lo_r     <= fixed[WIDTH-1:0];
                    state    <= ST_DONE;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = (state == ST_PREP) || (state == ST_CALC) || (state == ST_FIX);
    assign bus.done = (state == ST_DONE);
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;

endmodule

// File: tb/tb_seq_multiplier_16bit.sv
// Directed and random checks of the sequential multiplier against a
// behavioural product model, using a queue of expected results.
module tb_seq_multiplier_16bit;
    import seq_multiplier_16bit_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    seq_multiplier_16bit_if bus ();

    seq_multiplier_16bit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          checks  = 0;
    int          errors  = 0;
    int          overlap = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_res = '0;

    always @(negedge clk) begin
        if (rst_n && bus.busy === 1'b1 && bus.done === 1'b1) overlap++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic s, input logic [15:0] a, input logic [15:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic [31:0]        ua;
        logic [31:0]        ub;
        sa = {{16{a[15]}}, a};
        sb = {{16{b[15]}}, b};
        ua = {16'h0, a};
        ub = {16'h0, b};
        if (s) return sa * sb;
        return ua * ub;
    endfunction

    // Presents one request for a single cycle; returns just after the
    // accepting edge, with the operand bus scrambled to prove it was latched.
    task automatic start_op(input logic s, input logic [15:0] a, input logic [15:0] b);
        @(posedge clk);
        #1;
        bus.start     = 1'b1;
        bus.is_signed = s;
        bus.a         = a;
        bus.b         = b;
        exp_q.push_back(model(s, a, b));
        @(posedge clk);
        #1;
        bus.start     = 1'b0;
        bus.is_signed = ~s;
        bus.a         = 16'($urandom);
        bus.b         = 16'($urandom);
    endtask

    task automatic wait_done(input string tag);
        int          lat;
        bit          seen;
        logic [31:0] exp;
        lat  = 0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check($sformatf("%s latency", tag), 32'(lat), 32'd18);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        if (seen) begin
            check($sformatf("%s result", tag), {bus.hi, bus.lo}, exp);
            last_res = exp;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("%s done pulse", tag), {30'h0, bus.busy, bus.done}, 32'h0);
        end
    endtask

    initial begin
        int dones;
        int idle_dones;
        logic        rs;
        logic [15:0] ra;
        logic [15:0] rb;

        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.is_signed = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        repeat (3) @(negedge clk);
        check("reset outputs", {bus.busy, bus.done, 14'h0, bus.hi ^ bus.lo}, 32'h0);
        check("reset hi/lo", {bus.hi, bus.lo}, 32'h0);
        rst_n = 1'b1;

        // Directed products, including the boundary operands.
        start_op(1'b0, 16'hFFFF, 16'hFFFF); wait_done("multu ffff*ffff");
        start_op(1'b1, 16'hFFFF, 16'h0003); wait_done("mult -1*3");
        start_op(1'b1, 16'h8000, 16'h8000); wait_done("mult min*min");
        start_op(1'b1, 16'h0000, 16'h8000); wait_done("mult 0*min");
        start_op(1'b1, 16'h8000, 16'h0001); wait_done("mult min*1");
        start_op(1'b0, 16'h1234, 16'h0010); wait_done("multu 1234*10");

        // Reset in the middle of CALC drops the operation and clears hi/lo.
        start_op(1'b1, 16'h7FFF, 16'h7FFF);
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("busy mid calc", {31'h0, bus.busy}, 32'h1);
        check("hi/lo hold mid calc", {bus.hi, bus.lo}, last_res);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("abort busy/done", {30'h0, bus.busy, bus.done}, 32'h0);
        check("abort hi/lo", {bus.hi, bus.lo}, 32'h0);
        exp_q.delete();
        last_res = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle_dones = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) idle_dones++;
        end
        check("idle after reset", 32'(idle_dones), 32'd0);

        start_op(1'b0, 16'h00FF, 16'h0101); wait_done("multu after reset");

        // start held high: one done per accepted start, one accept per 20 cycles.
        @(posedge clk);
        #1;
        bus.start     = 1'b1;
        bus.is_signed = 1'b1;
        bus.a         = 16'h0102;
        bus.b         = 16'hFFFE;
        dones = 0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done === 1'b1) begin
                dones++;
                check($sformatf("held start result %0d", dones), {bus.hi, bus.lo},
                      model(1'b1, 16'h0102, 16'hFFFE));
                last_res = model(1'b1, 16'h0102, 16'hFFFE);
            end else if (i % 10 == 5) begin
                check($sformatf("held start hold %0d", i), {bus.hi, bus.lo}, last_res);
            end
        end
        bus.start = 1'b0;
        check("held start done count", 32'(dones), 32'd5);

        // Random operands, biased toward the sign/zero boundaries.
        for (int n = 0; n < 1500; n++) begin
            rs = 1'($urandom);
            ra = 16'($urandom);
            rb = 16'($urandom);
            case ($urandom_range(0, 7))
                0: ra = 16'h8000;
                1: rb = 16'h0000;
                2: rb = 16'hFFFF;
                3: ra = 16'h7FFF;
                default: ;
            endcase
            start_op(rs, ra, rb);
            wait_done($sformatf("random %0d s=%0b %04h*%04h", n, rs, ra, rb));
        end

        check("busy/done overlap", 32'(overlap), 32'd0);
        check("scoreboard empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
